// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its consumers (decode, later pipeline registers).
// Holds the text-segment constants and the fetch bundle carried through IF/ID.
package if_fetch_unit_pkg;

   localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
   localparam int          IM_WORDS  = 2048;
   localparam logic [31:0] NOP_INST  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
      logic        fault;
   } fetch_bundle_t;

   // Full-width compare so addresses far outside the memory never alias into it.
   function automatic logic fetch_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned words);
      logic [32:0] limit;
      limit = {1'b0, base} + ({1'b0, 32'(words)} << 2);
      return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus: combinational address out, word back in the same cycle.
interface if_fetch_unit_if;
   logic [31:0] im_addr;
   logic [31:0] im_inst;

   modport master (output im_addr, input  im_inst);
   modport slave  (input  im_addr, output im_inst);
endinterface

// File: rtl/if_fetch_unit_ifid_reg.sv
// Generic fetch-bundle pipeline register with stall-hold and flush-bubble controls.
// A bubble still records pc/pc4 so the debug view shows where the squash happened.
module if_fetch_unit_ifid_reg
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hold,
   input  logic          bubble,
   input  fetch_bundle_t d,
   output fetch_bundle_t q
);

   // Bubble outranks hold, so flush during a stall still squashes the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.inst  <= BUBBLE_INST;
         q.pc    <= '0;
         q.pc4   <= '0;
         q.valid <= 1'b0;
         q.fault <= 1'b0;
      end else if (bubble) begin
         q.inst  <= BUBBLE_INST;
         q.pc    <= d.pc;
         q.pc4   <= d.pc4;
         q.valid <= 1'b0;
         q.fault <= 1'b0;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// range-checks each fetch and loads the IF/ID register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 2048,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   if_fetch_unit_if.master         im,
   output logic [31:0]             pc,
   output logic [31:0]             ifid_inst,
   output logic [31:0]             ifid_pc,
   output logic [31:0]             ifid_pc4,
   output logic                    ifid_valid,
   output logic                    ifid_fault,
   output logic [31:0]             fetch_count
);
   import if_fetch_unit_pkg::*;

   logic [31:0]   pc_q;
   logic [31:0]   pc_d;
   logic [31:0]   pc_plus4;
   logic          fault;
   logic          bubble;
   logic          accept;
   logic [31:0]   count_q;
   fetch_bundle_t fetch_d;
   fetch_bundle_t ifid_q;

   assign im.im_addr = pc_q;
   assign pc         = pc_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign fault      = fetch_fault(pc_q, RESET_PC, int'(IM_WORDS));
   assign bubble     = flush | redirect_valid;
   assign accept     = !bubble && !stall;

   // Redirect targets are word-aligned silently; redirect overrides stall.
   always_comb begin
      pc_d = pc_plus4;
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   always_comb begin
      fetch_d       = '0;
      fetch_d.inst  = fault ? NOP_INST : im.im_inst;
      fetch_d.pc    = pc_q;
      fetch_d.pc4   = pc_plus4;
      fetch_d.valid = 1'b1;
      fetch_d.fault = fault;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         count_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (accept) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   if_fetch_unit_ifid_reg #(
      .BUBBLE_INST (NOP_INST)
   ) u_ifid_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (stall),
      .bubble (bubble),
      .d      (fetch_d),
      .q      (ifid_q)
   );

   assign ifid_inst   = ifid_q.inst;
   assign ifid_pc     = ifid_q.pc;
   assign ifid_pc4    = ifid_q.pc4;
   assign ifid_valid  = ifid_q.valid;
   assign ifid_fault  = ifid_q.fault;
   assign fetch_count = count_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined CPU; the initiator side of the instruction-memory read interface.
- Holds the PC and drives the combinational instruction-memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect, and flags misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; base of the text segment.
- IM_WORDS, 2048, instruction-memory depth in 32-bit words; with RESET_PC the legal fetch range is 0x3000 to 0x4FFC.
- NOP_INST, 32'h0000_0000, word injected as a bubble on flush or fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit holds PC and IF/ID.
- flush  in  1  squash the IF/ID contents next edge.
- redirect_valid  in  1  branch/jump taken, resolved in ID.
- redirect_pc  in  32  target PC.
- im_addr  out  32  address to instruction memory, equal to pc.
- im_inst  in  32  instruction word returned combinationally for im_addr.
- pc  out  32  current fetch PC.
- ifid_inst  out  32  IF/ID registered instruction.
- ifid_pc  out  32  IF/ID registered PC.
- ifid_pc4  out  32  IF/ID registered PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_fault  out  1  IF/ID instruction came from an illegal fetch address.
- fetch_count  out  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, independent of clk):
  - pc = RESET_PC.
  - ifid_inst = NOP_INST, ifid_pc = 0, ifid_pc4 = 0.
  - ifid_valid = 0, ifid_fault = 0, fetch_count = 0.
- Reset mid-operation discards all state. The first fetch after deassertion is at RESET_PC on the first rising edge where rst_n is high.
- im_addr = pc, purely combinational; memory latency is zero, so im_inst is sampled in the same cycle.
- fault = (pc[1:0] != 0) OR pc < RESET_PC OR pc >= RESET_PC + 4*IM_WORDS. Compute as a 32-bit unsigned compare, with no truncation to the memory index width.
- PC next-state priority, highest first:
  1. redirect_valid: pc <= {redirect_pc[31:2], 2'b00}, aligned silently. Overrides stall.
  2. stall: pc holds.
  3. Otherwise: pc <= pc + 4, with 32-bit wrap (0xFFFF_FFFC + 4 = 0). The wrapped address faults.
- IF/ID next-state priority, highest first:
  1. flush OR redirect_valid: bubble. ifid_inst = NOP_INST, ifid_valid = 0, ifid_fault = 0. ifid_pc and ifid_pc4 are loaded with the current pc and pc+4, for debug.
  2. stall: all IF/ID outputs hold.
  3. fault: ifid_inst = NOP_INST, ifid_valid = 1, ifid_fault = 1, ifid_pc = pc, ifid_pc4 = pc+4. Exception handling is downstream; fetch continues sequentially.
  4. Otherwise: ifid_inst = im_inst, ifid_pc = pc, ifid_pc4 = pc+4, ifid_valid = 1, ifid_fault = 0.
- fetch_count increments by 1 on every edge where case 3 or case 4 is taken; wraps at 2^32.
- Simultaneous events:
  - stall + flush: flush wins for IF/ID; PC still holds.
  - stall + redirect: PC takes the target, IF/ID bubbles.
  - flush + redirect: identical to redirect alone.
- Structure: no FSM beyond the PC and IF/ID registers. The fault path is a separate registered flag, not an encoded instruction.

Decomposition:
- Shared package holds:
  - TEXT_BASE (32'h0000_3000), IM_WORDS, NOP_INST.
  - A fetch-bundle struct {inst, pc, pc4, valid, fault}, used by if_fetch_unit and the decode stage.
- One natural sub-module: ifid_reg. It is the IF/ID pipeline register with stall-hold and flush-bubble controls, reusable for the later pipeline registers.
- PC logic and range check stay inline in if_fetch_unit.

Test Plan:
- Reset and run: rst_n low 3 cycles, then high; memory returns word = addr. Required:
  - pc sequence 0x3000, 0x3004, 0x3008.
  - One cycle later, ifid_inst = 0x3000 with ifid_valid = 1, ifid_pc4 = 0x3004.
  - fetch_count = 3 after 3 edges.
- Stall: at pc = 0x3008 assert stall 2 cycles. Required:
  - pc stays 0x3008 and IF/ID holds 0x3004 for both cycles.
  - On release, pc goes to 0x300C and ifid_pc = 0x3008.
  - fetch_count frozen during the stall.
- Redirect with stall: at pc = 0x3010 assert redirect_valid with redirect_pc = 0x3103, plus stall. Required:
  - Next pc = 0x3100, ifid_valid = 0, fetch_count unchanged.
  - Following edge: ifid_inst = word at 0x3100.
- Flush alone: assert flush 1 cycle at pc = 0x3020. Required:
  - ifid_valid = 0, ifid_inst = 0.
  - pc advances to 0x3024.
- Out-of-range fetch: redirect to 0x5000, then 0x2FFC. Required:
  - Each fetch gives ifid_fault = 1, ifid_inst = 0, ifid_valid = 1, ifid_pc equal to the faulting address.
  - fetch_count increments.
- Async reset mid-run: drop rst_n between edges while pc = 0x3040. Required:
  - pc = 0x3000, ifid_valid = 0, fetch_count = 0 before the next clk edge.
